// File: rtl/mult_input_conditioner.sv
// Input conditioning front end for a small sequential multiplier.
// Raw switches and a bouncy start button are synchronized, the button is
// debounced and edge-detected, and a two-state controller issues a single
// start pulse per accepted press. It latches the operands and reports either
// completion or a timeout through sticky flags.
module mult_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] sw_a,
    input  logic [3:0] sw_b,
    input  logic       btn_start,
    input  logic       done,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       start,
    output logic       busy,
    output logic       result_valid,
    output logic       timeout_err
);

    localparam int              DBW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]      TO_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Synchronizer stages, packed as {btn, sw_b, sw_a}
    logic [8:0]     sync_p0;
    logic [8:0]     sync_p1;

    logic           btn_s;
    logic [3:0]     sw_a_s;
    logic [3:0]     sw_b_s;

    logic [DBW-1:0] db_cnt;
    logic           deb;
    logic           deb_d;
    logic           btn_rise;

    state_t         state;
    state_t         state_nx;
    logic [7:0]     tcnt;
    logic [7:0]     tcnt_nx;
    logic [7:0]     tcnt_inc;
    logic [3:0]     a_nx;
    logic [3:0]     b_nx;
    logic           start_nx;
    logic           busy_nx;
    logic           rv_nx;
    logic           te_nx;

    // Two-flop synchronizer for every asynchronous input; only the second flop is consumed
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {btn_start, sw_b, sw_a};
            sync_p1 <= sync_p0;
        end
    end

    assign sw_a_s = sync_p1[3:0];
    assign sw_b_s = sync_p1[7:4];
    assign btn_s  = sync_p1[8];

    // Debounce: the level changes only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk) begin
        if (clr) begin
            db_cnt <= '0;
            deb    <= 1'b0;
            deb_d  <= 1'b0;
        end else begin
            deb_d <= deb;
            if (btn_s == deb) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                deb    <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Only a press matters; releases are deliberately ignored
    assign btn_rise = deb & ~deb_d;

    // Controller state, timeout counter and all registered outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= IDLE;
            tcnt         <= '0;
            a            <= '0;
            b            <= '0;
            start        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nx;
            tcnt         <= tcnt_nx;
            a            <= a_nx;
            b            <= b_nx;
            start        <= start_nx;
            busy         <= busy_nx;
            result_valid <= rv_nx;
            timeout_err  <= te_nx;
        end
    end

    // Next-state and next-output decode; done is ignored while start is still high
    // because it may be a leftover from the previous operation
    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        tcnt_inc = tcnt + 8'd1;
        a_nx     = a;
        b_nx     = b;
        start_nx = 1'b0;
        busy_nx  = busy;
        rv_nx    = result_valid;
        te_nx    = timeout_err;
        case (state)
            IDLE: begin
                if (btn_rise) begin
                    a_nx     = sw_a_s;
                    b_nx     = sw_b_s;
                    start_nx = 1'b1;
                    busy_nx  = 1'b1;
                    rv_nx    = 1'b0;
                    te_nx    = 1'b0;
                    tcnt_nx  = '0;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                tcnt_nx = tcnt_inc;
                if (!start && done) begin
                    busy_nx  = 1'b0;
                    rv_nx    = 1'b1;
                    te_nx    = 1'b0;
                    state_nx = IDLE;
                end else if (tcnt_inc == TO_LIMIT) begin
                    busy_nx  = 1'b0;
                    te_nx    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mult_input_conditioner.md
MULT_INPUT_CONDITIONER -- requirements
Module: mult_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable cycles before the debounced button level changes (legal range 2..2^24).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum cycles in WAIT without done before aborting (legal range 2..255).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port sw_a  input  4  raw multiplier switches, asynchronous.
REQ-006 SHALL have port sw_b  input  4  raw multiplicand switches, asynchronous.
REQ-007 SHALL have port btn_start  input  1  raw start push-button, asynchronous, bouncy.
REQ-008 SHALL have port done  input  1  completion from the downstream sequential multiplier, synchronous to clk.
REQ-009 SHALL have port a  output  4  latched multiplier operand.
REQ-010 SHALL have port b  output  4  latched multiplicand operand.
REQ-011 SHALL have port start  output  1  one-cycle start pulse to the multiplier.
REQ-012 SHALL have port busy  output  1  high while an operation is outstanding.
REQ-013 SHALL have port result_valid  output  1  sticky flag: last operation completed with done.
REQ-014 SHALL have port timeout_err  output  1  sticky flag: last operation aborted by timeout.

Function
REQ-015 SHALL pass sw_a, sw_b, btn_start each through a 2-flop synchronizer; downstream logic uses only the second flop.
REQ-016 SHALL debounce the synchronized button: counter increments each cycle synced level != debounced level, clears to 0 each cycle they are equal; when counter == DEBOUNCE_CYCLES-1 and still unequal, debounced level takes synced level and counter clears.
REQ-017 SHALL detect a debounced rising edge as debounced==1 and its one-cycle-delayed copy==0; falling edges produce no action.
REQ-018 SHALL implement FSM states IDLE and WAIT only; all outputs registered.
REQ-019 IDLE: on debounced rising edge -> at that clock edge latch a/b from synchronized switches, set start=1, busy=1, clear result_valid and timeout_err, clear timeout counter, go to WAIT.
REQ-020 start SHALL be high for exactly one cycle (the first WAIT cycle) per accepted press.
REQ-021 Latency: btn_start stable high from before edge k -> start high in the cycle following edge k+2+DEBOUNCE_CYCLES.
REQ-022 WAIT: done SHALL be ignored during the cycle start is high (stale done from prior operation).
REQ-023 WAIT: done sampled high in any later cycle -> busy=0, result_valid=1, go to IDLE.
REQ-024 WAIT: timeout counter increments each cycle; on reaching TIMEOUT_CYCLES without done -> busy=0, timeout_err=1, result_valid stays 0, go to IDLE.
REQ-025 Simultaneous done and timeout at the same edge: done wins (result_valid=1, timeout_err=0).
REQ-026 Button presses/edges during WAIT SHALL be ignored and SHALL NOT be queued; a new start requires release and re-press after return to IDLE.
REQ-027 a and b SHALL hold their latched values unchanged until the next accepted press, regardless of switch activity.
REQ-028 done while IDLE SHALL be ignored (no flag change).

Reset
REQ-029 clr high at a clock edge SHALL clear synchronizers, debounce counter, debounced level and its delayed copy, timeout counter; state=IDLE; a=0, b=0, start=0, busy=0, result_valid=0, timeout_err=0.
REQ-030 clr SHALL take priority over every other event, including mid-WAIT and the start cycle; the pending operation is abandoned with no flag set.
REQ-031 Button held through clr deassertion SHALL produce exactly one start, DEBOUNCE_CYCLES+3 edges after clr's last high edge.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16)
REQ-032 sw_a=4'h7, sw_b=4'h3, btn clean high from before edge 0 -> start high only between edges 6 and 7, a=7, b=3, busy=1; done pulse 5 cycles later -> busy=0, result_valid=1.
REQ-033 Bounce: btn toggles every 2 cycles for 20 cycles then holds high -> exactly one start, 7 edges after bounce ends.
REQ-034 No done after start -> after 16 WAIT cycles busy=0, timeout_err=1, result_valid=0; next press clears timeout_err.
REQ-035 Second press and sw_a change to 4'hF during WAIT -> no extra start, a stays 7; done -> IDLE with one start total.
REQ-036 clr asserted 2 cycles into WAIT with done arriving same cycle -> all outputs 0, state IDLE, result_valid=0.
